pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-address generator for the pipelined core, one stage ahead of instruction fetch. Each accepted cycle it selects the next PC from these sources: exception redirect, resolved branch, return-address-stack prediction, or sequential increment. It honours the pipeline stall vector and reports its own state for debug. It generalises the original single-source PC register to configurable width, reset vector, step size and a predicted-return path.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits
- RESET_VEC, 0, PC value loaded on reset and the first fetch address
- STEP, 4, sequential increment in bytes
- STALL_W, 6, width of the pipeline stall vector; bit 0 is the fetch stage
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- stall  in  STALL_W  pipeline stall vector; only stall[0] is used here
- exc_valid  in  1  exception/interrupt redirect request
- exc_addr  in  ADDR_W  exception handler address
- branch  in  1  resolved taken branch/jump
- branch_addr  in  ADDR_W  branch target
- call  in  1  call instruction committed; push call_link
- call_link  in  ADDR_W  return address to push
- ret  in  1  return instruction fetched; predict from stack
- pc  out  ADDR_W  current fetch address
- pc_valid  out  1  pc holds a fetchable address
- ret_miss  out  1  one-cycle pulse: ret accepted with empty stack
- ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries

## Operation
- Reset (rst=0 at an edge): pc=RESET_VEC, pc_valid=0, ret_miss=0, ras_count=0, stack pointer=0. Stack contents are don't-care.
- First edge with rst=1: pc_valid←1. pc is not advanced on that edge; RESET_VEC is the first fetched address.
- "Accepted" means rst=1, pc_valid=1 and stall[0]=0.
- Next-PC priority when rst=1 and pc_valid=1, highest first:
  1. exc_valid → pc←exc_addr and the stack is flushed (ras_count←0). This applies even when stall[0]=1.
  2. stall[0]=1 → pc holds. Nothing else changes, and call/ret/branch are ignored.
  3. branch → pc←branch_addr. No pop, even if ret is also set.
  4. ret with ras_count>0 → pc←top entry; pop.
  5. ret with ras_count=0 → pc←pc+STEP; ret_miss←1 for one cycle.
  6. Otherwise → pc←pc+STEP.
- Arithmetic is modulo 2^ADDR_W. pc+STEP wraps from the top of the address space to 0 silently.
- Push rules (accepted cycle, no exception): call writes call_link at the pointer and increments the pointer.
  - ras_count saturates at RAS_DEPTH.
  - On overflow the oldest entry is overwritten (circular buffer).
- call and ret in the same accepted cycle:
  - If the ret pop is selected (priority 4): pc←old top, and the top entry is replaced by call_link. Net ras_count is unchanged.
  - If branch has priority: the pop is suppressed and the push proceeds.
- call together with exc_valid: the push is discarded. The stack is empty after that edge.

## Timing
- Every redirect takes effect on pc one edge after the request is sampled. There is no combinational path from inputs to pc.
- ret_miss is registered. It asserts the edge after the offending ret and clears on the next edge unless a new miss occurs.
- ras_count updates on the same edge as the push or pop.
- A reset asserted mid-operation overrides all inputs on that edge.

## Configuration
- Macro PC_RAS_EN.
- Defined: the return address stack is built and behaves as above.
- Undefined:
  - call, call_link and ret are ignored; ret is treated as sequential.
  - ret_miss is tied to 0 and ras_count is tied to 0.
  - No stack storage is synthesised.
  - All other priorities are unchanged.

## Test plan
Defaults apply, with PC_RAS_EN defined unless noted.
- Reset and sequential fetch: hold rst=0 for 2 cycles, then release → pc=0, pc_valid=0 at the first post-reset edge, then pc_valid=1. pc then steps 0,4,8,C on consecutive edges.
- Stall and priority:
  - stall[0]=1 for 3 cycles with branch=1, branch_addr=0x100 → pc holds.
  - Assert exc_valid=1, exc_addr=0x80 while stalled → pc=0x80 next edge.
  - Release the stall with branch=1 and ret=1 → pc=0x100, ras_count unchanged.
- Return stack:
  - Push 0x10, 0x20, 0x30 via call. Then ret three times on successive accepted cycles → pc=0x30, 0x20, 0x10, and ras_count goes 3,2,1,0.
  - A fourth ret → pc=prev+4 and ret_miss pulses for exactly one cycle.
- Overflow: push 5 entries (0x1..0x5 ×0x10) into depth 4 → ras_count=4. Four rets → 0x50, 0x40, 0x30, 0x20; the fifth ret misses.
- Wrap and simultaneous ops:
  - Branch to 0xFFFFFFFC, then advance → pc=0x00000000.
  - With stack top 0x40, assert call (link 0x60) and ret together → pc=0x40, ras_count unchanged. A following ret → pc=0x60.
- Macro off: rebuild without PC_RAS_EN and repeat the return-stack test → pc advances by 4 on every ret, and ret_miss and ras_count stay 0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-address generator: exception, branch, return-stack or sequential next PC.
// Return-address stack is built only when PC_RAS_EN is defined.
module pc_gen #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int STEP = 4,
  parameter int STALL_W = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [STALL_W-1:0] stall,
  input  logic exc_valid,
  input  logic [ADDR_W-1:0] exc_addr,
  input  logic branch,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic call,
  input  logic [ADDR_W-1:0] call_link,
  input  logic ret,
  output logic [ADDR_W-1:0] pc,
  output logic pc_valid,
  output logic ret_miss,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic valid_q;
  logic [ADDR_W-1:0] seq_pc;

  assign seq_pc = pc_q + ADDR_W'(STEP);

`ifdef PC_RAS_EN
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, top, wr_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic miss_q, miss_d;
  logic hit, pop_sel, ras_we;
  logic unused;

  assign unused = ^stall[STALL_W-1:1];
  assign top = sp_q - PTR_W'(1);
  assign hit = ret & (cnt_q != '0);
  assign pop_sel = ~branch & hit;

  always_comb begin
    pc_d = pc_q;
    sp_d = sp_q;
    cnt_d = cnt_q;
    miss_d = 1'b0;
    ras_we = 1'b0;
    wr_idx = sp_q;
    if (valid_q) begin
      if (exc_valid) begin
        pc_d = exc_addr;
        sp_d = '0;
        cnt_d = '0;
      end else if (!stall[0]) begin
        if (branch) begin
          pc_d = branch_addr;
        end else if (hit) begin
          pc_d = ras_q[top];
        end else begin
          pc_d = seq_pc;
          miss_d = ret;
        end
        // call+ret pop: overwrite the popped slot, depth unchanged
        if (call) begin
          ras_we = 1'b1;
          if (pop_sel) begin
            wr_idx = top;
          end else begin
            sp_d = sp_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (pop_sel) begin
          sp_d = top;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q <= '0;
      cnt_q <= '0;
      miss_q <= 1'b0;
    end else begin
      sp_q <= sp_d;
      cnt_q <= cnt_d;
      miss_q <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && ras_we) ras_q[wr_idx] <= call_link;
  end

  assign ret_miss = miss_q;
  assign ras_count = cnt_q;
`else
  logic unused;

  assign unused = ^{call, call_link, ret, stall[STALL_W-1:1]};

  always_comb begin
    pc_d = pc_q;
    if (valid_q) begin
      if (exc_valid) pc_d = exc_addr;
      else if (!stall[0]) pc_d = branch ? branch_addr : seq_pc;
    end
  end

  assign ret_miss = 1'b0;
  assign ras_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_VEC;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      valid_q <= 1'b1;
    end
  end

  assign pc = pc_q;
  assign pc_valid = valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen against a queue-based stack model.
// Expectations follow PC_RAS_EN the same way the design build does.
module tb_pc_gen;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] stall = '0;
  logic exc_valid = 1'b0;
  logic [31:0] exc_addr = '0;
  logic branch = 1'b0;
  logic [31:0] branch_addr = '0;
  logic call = 1'b0;
  logic [31:0] call_link = '0;
  logic ret = 1'b0;
  logic [31:0] pc;
  logic pc_valid;
  logic ret_miss;
  logic [2:0] ras_count;

  pc_gen #(
    .ADDR_W(32), .RESET_VEC(32'h0), .STEP(4),
    .STALL_W(6), .RAS_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .exc_valid(exc_valid), .exc_addr(exc_addr),
    .branch(branch), .branch_addr(branch_addr),
    .call(call), .call_link(call_link), .ret(ret),
    .pc(pc), .pc_valid(pc_valid),
    .ret_miss(ret_miss), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r; bit [5:0] st; bit e; logic [31:0] ea;
    bit b; logic [31:0] ba; bit c; logic [31:0] cl; bit t;
  } stim_t;

  int nchk = 0;
  int npass = 0;

  logic [31:0] m_pc = '0;
  bit m_valid = 1'b0;
  bit m_miss = 1'b0;
  logic [31:0] m_stk[$];

  function automatic stim_t S(bit r, bit [5:0] st, bit e, logic [31:0] ea,
                              bit b, logic [31:0] ba, bit c,
                              logic [31:0] cl, bit t);
    stim_t s;
    s.r = r; s.st = st; s.e = e; s.ea = ea;
    s.b = b; s.ba = ba; s.c = c; s.cl = cl; s.t = t;
    return s;
  endfunction

  function automatic stim_t idle();
    return S(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t do_call(logic [31:0] a);
    return S(1, 0, 0, 0, 0, 0, 1, a, 0);
  endfunction

  function automatic stim_t do_ret();
    return S(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Drive one cycle and advance the reference model on the same edge.
  task automatic step(input stim_t s);
    bit swapped;
    rst = s.r; stall = s.st; exc_valid = s.e; exc_addr = s.ea;
    branch = s.b; branch_addr = s.ba;
    call = s.c; call_link = s.cl; ret = s.t;
    @(posedge clk);
    swapped = 1'b0;
    if (!s.r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_miss = 1'b0;
      m_stk.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1; m_miss = 1'b0;
    end else begin
      m_miss = 1'b0;
      if (s.e) begin
        m_pc = s.ea;
        m_stk.delete();
      end else if (!s.st[0]) begin
        if (s.b) begin
          m_pc = s.ba;
        end else if (RAS && s.t && m_stk.size() > 0) begin
          m_pc = m_stk[m_stk.size()-1];
          if (s.c) begin
            m_stk[m_stk.size()-1] = s.cl;
            swapped = 1'b1;
          end else begin
            void'(m_stk.pop_back());
          end
        end else begin
          m_pc = m_pc + 32'd4;
          if (RAS && s.t) m_miss = 1'b1;
        end
        if (RAS && s.c && !swapped) begin
          if (m_stk.size() == D) void'(m_stk.pop_front());
          m_stk.push_back(s.cl);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t v[$];
    v.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(S(0, 0, 1, 32'h44, 1, 32'h88, 1, 32'h9, 1));
    for (int i = 0; i < 5; i++) v.push_back(idle());
    foreach (v[i]) begin
      step(v[i]);
      nchk++;
      if ({pc, pc_valid, ret_miss, ras_count} !==
          {m_pc, m_valid, m_miss, 3'(m_stk.size())})
        $display("FAIL reset[%0d] got pc=%h v=%b m=%b n=%0d want pc=%h v=%b m=%b n=%0d",
                 i, pc, pc_valid, ret_miss, ras_count,
                 m_pc, m_valid, m_miss, m_stk.size());
      else npass++;
    end
  endtask

  task automatic test_stall_priority();
    stim_t v[$];
    v.push_back(do_call(32'h200));
    for (int i = 0; i < 3; i++)
      v.push_back(S(1, 6'h01, 0, 0, 1, 32'h100, 1, 32'h300, 1));
    v.push_back(S(1, 6'h01, 1, 32'h80, 0, 0, 1, 32'h400, 0));
    v.push_back(do_call(32'h500));
    v.push_back(S(1, 0, 0, 0, 1, 32'h100, 0, 0, 1));
    v.push_back(S(1, 6'h3e, 0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      step(v[i]);
      nchk++;
      if ({pc, pc_valid, ret_miss, ras_count} !==
          {m_pc, m_valid, m_miss, 3'(m_stk.size())})
        $display("FAIL stall_prio[%0d] got pc=%h m=%b n=%0d want pc=%h m=%b n=%0d",
                 i, pc, ret_miss, ras_count, m_pc, m_miss, m_stk.size());
      else npass++;
    end
  endtask

  task automatic test_ras();
    stim_t v[$];
    v.push_back(do_call(32'h10));
    v.push_back(do_call(32'h20));
    v.push_back(do_call(32'h30));
    for (int i = 0; i < 4; i++) v.push_back(do_ret());
    v.push_back(idle());
    v.push_back(idle());
    foreach (v[i]) begin
      step(v[i]);
      nchk++;
      if ({pc, ret_miss, ras_count} !== {m_pc, m_miss, 3'(m_stk.size())})
        $display("FAIL ras[%0d] got pc=%h m=%b n=%0d want pc=%h m=%b n=%0d",
                 i, pc, ret_miss, ras_count, m_pc, m_miss, m_stk.size());
      else npass++;
    end
  endtask

  task automatic test_overflow();
    stim_t v[$];
    for (int i = 1; i <= 5; i++) v.push_back(do_call(32'(i * 16)));
    for (int i = 0; i < 5; i++) v.push_back(do_ret());
    v.push_back(idle());
    foreach (v[i]) begin
      step(v[i]);
      nchk++;
      if ({pc, ret_miss, ras_count} !== {m_pc, m_miss, 3'(m_stk.size())})
        $display("FAIL overflow[%0d] got pc=%h m=%b n=%0d want pc=%h m=%b n=%0d",
                 i, pc, ret_miss, ras_count, m_pc, m_miss, m_stk.size());
      else npass++;
    end
  endtask

  task automatic test_wrap_simul();
    stim_t v[$];
    v.push_back(S(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0));
    v.push_back(idle());
    v.push_back(do_call(32'h40));
    v.push_back(S(1, 0, 0, 0, 0, 0, 1, 32'h60, 1));
    v.push_back(do_ret());
    v.push_back(do_call(32'h70));
    v.push_back(S(1, 0, 0, 0, 1, 32'h900, 1, 32'h80, 1));
    v.push_back(do_ret());
    v.push_back(S(1, 0, 0, 0, 0, 0, 1, 32'hA0, 1));
    v.push_back(S(0, 0, 0, 0, 1, 32'h123, 1, 32'h5, 1));
    v.push_back(idle());
    v.push_back(idle());
    foreach (v[i]) begin
      step(v[i]);
      nchk++;
      if ({pc, pc_valid, ret_miss, ras_count} !==
          {m_pc, m_valid, m_miss, 3'(m_stk.size())})
        $display("FAIL wrap_simul[%0d] got pc=%h v=%b m=%b n=%0d want pc=%h v=%b m=%b n=%0d",
                 i, pc, pc_valid, ret_miss, ras_count,
                 m_pc, m_valid, m_miss, m_stk.size());
      else npass++;
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 800; i++) begin
      s = idle();
      s.r = ($urandom_range(99) != 0);
      s.st = ($urandom_range(5) == 0) ? 6'($urandom | 1) : 6'($urandom & 6'h3e);
      s.e = ($urandom_range(19) == 0);
      s.ea = $urandom & 32'hFFFF_FFFC;
      s.b = ($urandom_range(7) == 0);
      s.ba = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFC);
      s.c = ($urandom_range(2) == 0);
      s.cl = $urandom & 32'hFFFC;
      s.t = ($urandom_range(2) == 0);
      step(s);
      nchk++;
      if ({pc, pc_valid, ret_miss, ras_count} !==
          {m_pc, m_valid, m_miss, 3'(m_stk.size())})
        $display("FAIL random[%0d] got pc=%h v=%b m=%b n=%0d want pc=%h v=%b m=%b n=%0d",
                 i, pc, pc_valid, ret_miss, ras_count,
                 m_pc, m_valid, m_miss, m_stk.size());
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_ras();
    test_overflow();
    test_wrap_simul();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
